// File: rtl/cc_rd_fill_pkg.sv
// Shared constants for the CC_RD_FILL family: FSM states, error codes and
// fill-header bit positions.
package cc_rd_fill_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SEL,
      ST_WAIT_ACQ,
      ST_CHK,
      ST_GET_HDR,
      ST_ERROR,
      ST_ECHO_CSN1,
      ST_ECHO_CSN2,
      ST_ECHO_CC1,
      ST_ECHO_CC2,
      ST_GET_DDR3,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE        = 2'd0,
      ERR_FIFO_EMPTY  = 2'd1,
      ERR_ACQ_TIMEOUT = 2'd2,
      ERR_BAD_REQ     = 2'd3
   } err_e;

   localparam int ASYNC_BIT    = 26;
   localparam int SELFTRIG_BIT = 123;
   localparam int TRIG_SEL_BIT = 24;
   localparam int ADDR_LSB     = 53;
   localparam int BURST_LSB    = 128;

   function automatic int chan_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cc_fill_hdr_decode.sv
// Selects one channel's FWFT header head and decodes the DDR3 start address,
// burst count and zero-burst flag. Purely combinational.
module cc_fill_hdr_decode
   import cc_rd_fill_pkg::*;
#(
   parameter int NUM_CHAN = 5,
   parameter int ADDR_W   = 23,
   parameter int BURST_W  = 24,
   parameter int HDR_W    = 152,
   parameter int CHAN_W   = chan_w(NUM_CHAN)
) (
   input  logic [NUM_CHAN*HDR_W-1:0] hdr_fifo_out,
   input  logic [CHAN_W-1:0]         chan,
   input  logic                      en_fixed_start_addr,
   input  logic [ADDR_W-1:0]         fixed_start_addr,
   output logic [ADDR_W-1:0]         start_addr,
   output logic [BURST_W-1:0]        burst_cnt,
   output logic                      zero_burst
);

   logic [HDR_W-1:0] hdr;
   logic             unused_hdr;

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      hdr = '0;
      for (int c = 0; c < NUM_CHAN; c++) begin
         if (int'(chan) == c) hdr = hdr_fifo_out[c*HDR_W +: HDR_W];
      end
   end

   // Address source priority: software override, async trigger, self trigger, header field.
   always_comb begin
      if (en_fixed_start_addr)     start_addr = fixed_start_addr;
      else if (hdr[ASYNC_BIT])     start_addr = '0;
      else if (hdr[SELFTRIG_BIT])  start_addr = {hdr[TRIG_SEL_BIT], {(ADDR_W-1){1'b0}}};
      else                         start_addr = hdr[ADDR_LSB +: ADDR_W];
   end

   assign burst_cnt  = hdr[BURST_LSB +: BURST_W];
   assign zero_burst = (burst_cnt == '0);
   assign unused_hdr = ^hdr;

endmodule

// File: rtl/cc_rd_fill_mc_sm.sv
// Multi-channel CC_RD_FILL command machine: picks a channel header FIFO, waits for
// its acquisition, pops the header, echoes CSN/CC and then streams DDR3 data.
module cc_rd_fill_mc_sm
   import cc_rd_fill_pkg::*;
#(
   parameter int NUM_CHAN = 5,
   parameter int ADDR_W   = 23,
   parameter int BURST_W  = 24,
   parameter int HDR_W    = 152,
   parameter int TO_W     = 24,
   parameter int CHAN_W   = chan_w(NUM_CHAN)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      run_sm,
   input  logic [CHAN_W-1:0]         chan_sel,
   input  logic [TO_W-1:0]           timeout_limit,
   output logic                      sm_running,
   output logic                      sm_done,
   output logic                      tx_tvalid,
   output logic                      tx_tlast,
   input  logic                      tx_tready,
   output logic                      send_csn,
   output logic                      send_cmd,
   output logic                      send_inv_cmd,
   input  logic [NUM_CHAN-1:0]       hdr_fifo_empty,
   output logic [NUM_CHAN-1:0]       hdr_fifo_rd_en,
   input  logic [NUM_CHAN*HDR_W-1:0] hdr_fifo_out,
   input  logic [NUM_CHAN-1:0]       acq_done_latch,
   input  logic [ADDR_W-1:0]         fixed_start_addr,
   input  logic                      en_fixed_start_addr,
   output logic [ADDR_W-1:0]         ddr3_rd_start_addr,
   output logic [BURST_W-1:0]        ddr3_rd_burst_cnt,
   output logic                      enable_reading,
   input  logic                      reading_done,
   output logic                      use_ddr3_data,
   input  logic                      aurora_ddr3_accept,
   output logic [1:0]                err_code,
   output logic [15:0]               fill_count
);

   state_e                cs_q, ns;
   logic [CHAN_W-1:0]     ch_q, ch_d;
   logic [TO_W-1:0]       to_cnt_q, to_cnt_d, to_cnt_inc;
   logic [ADDR_W-1:0]     addr_q, addr_d, dec_addr;
   logic [BURST_W-1:0]    burst_q, burst_d, dec_burst;
   logic                  zero_burst_q, zero_burst_d, dec_zero;
   logic [BURST_W+1:0]    words_q, words_d;
   logic                  words_zero_q;
   logic                  err_q, err_d;
   err_e                  err_code_q, err_code_d;
   logic [15:0]           fill_cnt_q, fill_cnt_d;
   logic                  rd_sync1_q, rd_sync2_q;
   logic                  ch_valid, acq_sel, empty_sel;

   logic                  running_q, running_d, done_q, done_d;
   logic                  tvalid_q, tvalid_d, tlast_q, tlast_d;
   logic                  csn_q, csn_d, cmd_q, cmd_d, inv_q, inv_d;
   logic [NUM_CHAN-1:0]   rd_en_q, rd_en_d;
   logic                  en_rd_q, en_rd_d, use_q, use_d;

   cc_fill_hdr_decode #(
      .NUM_CHAN (NUM_CHAN),
      .ADDR_W   (ADDR_W),
      .BURST_W  (BURST_W),
      .HDR_W    (HDR_W),
      .CHAN_W   (CHAN_W)
   ) u_hdr_decode (
      .hdr_fifo_out        (hdr_fifo_out),
      .chan                (ch_q),
      .en_fixed_start_addr (en_fixed_start_addr),
      .fixed_start_addr    (fixed_start_addr),
      .start_addr          (dec_addr),
      .burst_cnt           (dec_burst),
      .zero_burst          (dec_zero)
   );

   assign ch_valid   = int'(ch_q) < NUM_CHAN;
   assign to_cnt_inc = to_cnt_q + TO_W'(1);

   always_comb begin
      acq_sel   = 1'b0;
      empty_sel = 1'b0;
      for (int c = 0; c < NUM_CHAN; c++) begin
         if (int'(ch_q) == c) begin
            acq_sel   = acq_done_latch[c];
            empty_sel = hdr_fifo_empty[c];
         end
      end
   end

   always_comb begin
      ns           = cs_q;
      ch_d         = ch_q;
      to_cnt_d     = to_cnt_q;
      addr_d       = addr_q;
      burst_d      = burst_q;
      zero_burst_d = zero_burst_q;
      words_d      = words_q;
      err_d        = err_q;
      err_code_d   = err_code_q;
      fill_cnt_d   = fill_cnt_q;

      case (cs_q)
         ST_IDLE: begin
            if (run_sm) begin
               ns         = ST_SEL;
               ch_d       = chan_sel;
               err_d      = 1'b0;
               err_code_d = ERR_NONE;
            end
         end
         ST_SEL: begin
            if (!ch_valid) begin
               ns         = ST_ERROR;
               err_code_d = ERR_BAD_REQ;
            end else begin
               ns       = ST_WAIT_ACQ;
               to_cnt_d = '0;
            end
         end
         ST_WAIT_ACQ: begin
            // acq_done wins over a coincident timeout.
            if (acq_sel) begin
               ns = ST_CHK;
            end else if (timeout_limit != '0 && to_cnt_inc == timeout_limit) begin
               ns         = ST_ERROR;
               err_code_d = ERR_ACQ_TIMEOUT;
            end else begin
               to_cnt_d = to_cnt_inc;
            end
         end
         ST_CHK: begin
            if (empty_sel) begin
               ns         = ST_ERROR;
               err_code_d = ERR_FIFO_EMPTY;
            end else begin
               ns           = ST_GET_HDR;
               addr_d       = dec_addr;
               burst_d      = dec_burst;
               zero_burst_d = dec_zero;
               words_d      = {dec_burst, 2'b00};
            end
         end
         ST_GET_HDR: begin
            if (zero_burst_q) begin
               ns         = ST_ERROR;
               err_code_d = ERR_BAD_REQ;
            end else begin
               ns = ST_ECHO_CSN1;
            end
         end
         ST_ERROR: begin
            err_d = 1'b1;
            ns    = ST_ECHO_CSN1;
         end
         ST_ECHO_CSN1: if (tx_tready) ns = ST_ECHO_CSN2;
         ST_ECHO_CSN2: ns = ST_ECHO_CC1;
         ST_ECHO_CC1:  if (tx_tready) ns = ST_ECHO_CC2;
         ST_ECHO_CC2:  ns = err_q ? ST_DONE : ST_GET_DDR3;
         ST_GET_DDR3: begin
            if (aurora_ddr3_accept && words_q != '0) words_d = words_q - 1'b1;
            if (rd_sync2_q && words_zero_q) ns = ST_DONE;
         end
         ST_DONE: ns = ST_IDLE;
         default: ns = ST_IDLE;
      endcase

      if (!run_sm) ns = ST_IDLE;
      if (ns == ST_DONE && !err_d) fill_cnt_d = fill_cnt_q + 16'd1;
   end

   // Outputs are decoded from the next state so they are valid on state entry.
   always_comb begin
      running_d = (ns != ST_IDLE);
      done_d    = (ns == ST_DONE);
      tvalid_d  = (ns == ST_ECHO_CSN2) || (ns == ST_ECHO_CC2);
      tlast_d   = (ns == ST_ECHO_CC2) && err_d;
      csn_d     = (ns == ST_ECHO_CSN1) || (ns == ST_ECHO_CSN2);
      cmd_d     = (ns == ST_ECHO_CC1) && !err_d;
      inv_d     = (ns == ST_ECHO_CC1) && err_d;
      en_rd_d   = (ns == ST_GET_DDR3);
      use_d     = en_rd_d || ((ns == ST_DONE) && !err_d);
      rd_en_d   = '0;
      for (int c = 0; c < NUM_CHAN; c++) begin
         rd_en_d[c] = (ns == ST_GET_HDR) && (int'(ch_q) == c);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cs_q         <= ST_IDLE;
         ch_q         <= '0;
         to_cnt_q     <= '0;
         addr_q       <= '0;
         burst_q      <= '0;
         zero_burst_q <= 1'b0;
         words_q      <= '0;
         words_zero_q <= 1'b1;
         err_q        <= 1'b0;
         err_code_q   <= ERR_NONE;
         fill_cnt_q   <= '0;
         rd_sync1_q   <= 1'b0;
         rd_sync2_q   <= 1'b0;
         running_q    <= 1'b0;
         done_q       <= 1'b0;
         tvalid_q     <= 1'b0;
         tlast_q      <= 1'b0;
         csn_q        <= 1'b0;
         cmd_q        <= 1'b0;
         inv_q        <= 1'b0;
         rd_en_q      <= '0;
         en_rd_q      <= 1'b0;
         use_q        <= 1'b0;
      end else begin
         cs_q         <= ns;
         ch_q         <= ch_d;
         to_cnt_q     <= to_cnt_d;
         addr_q       <= addr_d;
         burst_q      <= burst_d;
         zero_burst_q <= zero_burst_d;
         words_q      <= words_d;
         words_zero_q <= (words_d == '0);
         err_q        <= err_d;
         err_code_q   <= err_code_d;
         fill_cnt_q   <= fill_cnt_d;
         // reading_done comes from another clock domain.
         rd_sync1_q   <= reading_done;
         rd_sync2_q   <= rd_sync1_q;
         running_q    <= running_d;
         done_q       <= done_d;
         tvalid_q     <= tvalid_d;
         tlast_q      <= tlast_d;
         csn_q        <= csn_d;
         cmd_q        <= cmd_d;
         inv_q        <= inv_d;
         rd_en_q      <= rd_en_d;
         en_rd_q      <= en_rd_d;
         use_q        <= use_d;
      end
   end

   assign sm_running         = running_q;
   assign sm_done            = done_q;
   assign tx_tvalid          = tvalid_q;
   assign tx_tlast           = tlast_q;
   assign send_csn           = csn_q;
   assign send_cmd           = cmd_q;
   assign send_inv_cmd       = inv_q;
   assign hdr_fifo_rd_en     = rd_en_q;
   assign enable_reading     = en_rd_q;
   assign use_ddr3_data      = use_q;
   assign ddr3_rd_start_addr = addr_q;
   assign ddr3_rd_burst_cnt  = burst_q;
   assign err_code           = err_code_q;
   assign fill_count         = fill_cnt_q;

endmodule

// File: tb/tb_cc_rd_fill_mc_sm.sv
// Directed self-checking bench for cc_rd_fill_mc_sm: normal fill, error paths,
// address priority, backpressure, abort and done timing.
module tb_cc_rd_fill_mc_sm;

   localparam int NUM_CHAN = 5;
   localparam int ADDR_W   = 23;
   localparam int BURST_W  = 24;
   localparam int HDR_W    = 152;
   localparam int TO_W     = 24;
   localparam int CHAN_W   = 3;

   logic                      clk = 1'b0;
   logic                      reset_n;
   logic                      run_sm;
   logic [CHAN_W-1:0]         chan_sel;
   logic [TO_W-1:0]           timeout_limit;
   logic                      sm_running, sm_done, tx_tvalid, tx_tlast, tx_tready;
   logic                      send_csn, send_cmd, send_inv_cmd;
   logic [NUM_CHAN-1:0]       hdr_fifo_empty, hdr_fifo_rd_en, acq_done_latch;
   logic [NUM_CHAN*HDR_W-1:0] hdr_fifo_out;
   logic [ADDR_W-1:0]         fixed_start_addr, ddr3_rd_start_addr;
   logic                      en_fixed_start_addr;
   logic [BURST_W-1:0]        ddr3_rd_burst_cnt;
   logic                      enable_reading, reading_done, use_ddr3_data, aurora_ddr3_accept;
   logic [1:0]                err_code;
   logic [15:0]               fill_count;
   logic [15:0]               ctrl_outs;

   int n_tests = 0;
   int n_fail  = 0;
   int rd_pulses, tv_cnt, tl_cnt, en_cnt, inv_cnt, cmd_cnt, done_cnt;
   int multihot_all = 0;
   int overlap_all  = 0;
   logic [NUM_CHAN-1:0] rd_or;
   int n;

   always #5 clk = ~clk;

   cc_rd_fill_mc_sm dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .run_sm              (run_sm),
      .chan_sel            (chan_sel),
      .timeout_limit       (timeout_limit),
      .sm_running          (sm_running),
      .sm_done             (sm_done),
      .tx_tvalid           (tx_tvalid),
      .tx_tlast            (tx_tlast),
      .tx_tready           (tx_tready),
      .send_csn            (send_csn),
      .send_cmd            (send_cmd),
      .send_inv_cmd        (send_inv_cmd),
      .hdr_fifo_empty      (hdr_fifo_empty),
      .hdr_fifo_rd_en      (hdr_fifo_rd_en),
      .hdr_fifo_out        (hdr_fifo_out),
      .acq_done_latch      (acq_done_latch),
      .fixed_start_addr    (fixed_start_addr),
      .en_fixed_start_addr (en_fixed_start_addr),
      .ddr3_rd_start_addr  (ddr3_rd_start_addr),
      .ddr3_rd_burst_cnt   (ddr3_rd_burst_cnt),
      .enable_reading      (enable_reading),
      .reading_done        (reading_done),
      .use_ddr3_data       (use_ddr3_data),
      .aurora_ddr3_accept  (aurora_ddr3_accept),
      .err_code            (err_code),
      .fill_count          (fill_count)
   );

   assign ctrl_outs = {sm_running, sm_done, tx_tvalid, tx_tlast, send_csn, send_cmd,
                       send_inv_cmd, hdr_fifo_rd_en, enable_reading, use_ddr3_data, err_code};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [HDR_W-1:0] make_hdr(input logic [BURST_W-1:0] burst,
                                                 input logic [ADDR_W-1:0] addr,
                                                 input logic async_f, input logic st_f,
                                                 input logic ts_f);
      logic [HDR_W-1:0] h;
      h           = '0;
      h[128 +: 24] = burst;
      h[53 +: 23]  = addr;
      h[26]        = async_f;
      h[123]       = st_f;
      h[24]        = ts_f;
      return h;
   endfunction

   task automatic set_hdr(input int c, input logic [HDR_W-1:0] h);
      hdr_fifo_out[c*HDR_W +: HDR_W] = h;
   endtask

   task automatic clr_mon();
      rd_pulses = 0; tv_cnt = 0; tl_cnt = 0; en_cnt = 0;
      inv_cnt = 0; cmd_cnt = 0; done_cnt = 0; rd_or = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (|hdr_fifo_rd_en) rd_pulses++;
      rd_or |= hdr_fifo_rd_en;
      if ($countones(hdr_fifo_rd_en) > 1) multihot_all++;
      if (int'(send_csn) + int'(send_cmd) + int'(send_inv_cmd) > 1) overlap_all++;
      if (tx_tvalid)      tv_cnt++;
      if (tx_tlast)       tl_cnt++;
      if (enable_reading) en_cnt++;
      if (send_inv_cmd)   inv_cnt++;
      if (send_cmd)       cmd_cnt++;
      if (sm_done)        done_cnt++;
   endtask

   task automatic run_to_ddr3(input string tag);
      int k = 0;
      while (!enable_reading && k < 40) begin
         step();
         k++;
      end
      check(tag, enable_reading, 1);
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (!sm_done && k < 60) begin
         step();
         k++;
      end
      check(tag, sm_done, 1);
      run_sm       = 1'b0;
      reading_done = 1'b0;
   endtask

   task automatic abort();
      run_sm = 1'b0;
      step();
   endtask

   initial begin
      reset_n = 1'b0; run_sm = 1'b0; chan_sel = '0; timeout_limit = '0;
      tx_tready = 1'b1; hdr_fifo_empty = 5'b00010; acq_done_latch = 5'b01110;
      hdr_fifo_out = '0; fixed_start_addr = '0; en_fixed_start_addr = 1'b0;
      reading_done = 1'b0; aurora_ddr3_accept = 1'b0;
      clr_mon();
      #23;
      check("reset_ctrl_outs", 32'(ctrl_outs), 0);
      check("reset_fill_count", 32'(fill_count), 0);
      check("reset_addr_burst", 32'(ddr3_rd_start_addr) | 32'(ddr3_rd_burst_cnt), 0);
      reset_n = 1'b1;
      step();
      check("idle_after_reset", 32'(ctrl_outs), 0);

      // Normal fill on channel 2.
      set_hdr(2, make_hdr(24'd4, 23'h1234, 1'b0, 1'b0, 1'b0));
      chan_sel = 3'd2; clr_mon(); run_sm = 1'b1;
      run_to_ddr3("t1_reach_ddr3");
      check("t1_rd_pulses", rd_pulses, 1);
      check("t1_rd_chan", 32'(rd_or), 32'h4);
      check("t1_start_addr", 32'(ddr3_rd_start_addr), 32'h1234);
      check("t1_burst", 32'(ddr3_rd_burst_cnt), 4);
      check("t1_echo_words", tv_cnt, 2);
      check("t1_no_tlast", tl_cnt, 0);
      check("t1_use_ddr3", 32'(use_ddr3_data), 1);
      aurora_ddr3_accept = 1'b1;
      repeat (16) step();
      aurora_ddr3_accept = 1'b0;
      check("t1_no_done_before_rd", done_cnt, 0);
      reading_done = 1'b1;
      wait_done("t1_done");
      check("t1_fill_count", 32'(fill_count), 1);
      check("t1_use_at_done", 32'(use_ddr3_data), 1);
      check("t1_err_none", 32'(err_code), 0);
      step();
      check("t1_idle", 32'(sm_running), 0);

      // Empty FIFO on channel 1.
      chan_sel = 3'd1; clr_mon(); run_sm = 1'b1;
      wait_done("t2_done");
      check("t2_err_code", 32'(err_code), 1);
      check("t2_no_rd_en", rd_pulses, 0);
      check("t2_no_enable", en_cnt, 0);
      check("t2_echo_words", tv_cnt, 2);
      check("t2_tlast", tl_cnt, 1);
      check("t2_inv_cmd_seen", 32'(inv_cnt > 0), 1);
      check("t2_no_cmd", cmd_cnt, 0);
      check("t2_no_use_at_done", 32'(use_ddr3_data), 0);
      step(); step();
      check("t2_err_held_idle", 32'(err_code), 1);
      check("t2_single_done", done_cnt, 1);
      check("t2_fill_count", 32'(fill_count), 1);

      // Acquisition timeout on channel 0.
      chan_sel = 3'd0; timeout_limit = 24'd10; clr_mon(); run_sm = 1'b1;
      step();
      check("t3_running", 32'(sm_running), 1);
      check("t3_err_cleared", 32'(err_code), 0);
      n = 0;
      while (err_code != 2'd2 && n < 40) begin
         step();
         n++;
      end
      check("t3_timeout_cycles", n, 11);
      wait_done("t3_done");
      check("t3_tlast", tl_cnt, 1);
      step();
      timeout_limit = '0; clr_mon(); run_sm = 1'b1;
      repeat (1000) step();
      check("t3_wait_forever_running", 32'(sm_running), 1);
      check("t3_wait_forever_no_err", 32'(err_code), 0);
      check("t3_wait_forever_no_echo", tv_cnt + rd_pulses, 0);
      abort();
      check("t3_abort_idle", 32'(ctrl_outs), 0);

      // Start-address priority on channel 3.
      chan_sel = 3'd3;
      set_hdr(3, make_hdr(24'd1, 23'h1234, 1'b1, 1'b0, 1'b0));
      en_fixed_start_addr = 1'b1; fixed_start_addr = 23'h7; run_sm = 1'b1;
      run_to_ddr3("t4a_reach");
      check("t4a_fixed_addr", 32'(ddr3_rd_start_addr), 32'h7);
      abort();
      en_fixed_start_addr = 1'b0; run_sm = 1'b1;
      run_to_ddr3("t4b_reach");
      check("t4b_async_addr", 32'(ddr3_rd_start_addr), 0);
      abort();
      set_hdr(3, make_hdr(24'd1, 23'h1234, 1'b0, 1'b1, 1'b1));
      run_sm = 1'b1;
      run_to_ddr3("t4c_reach");
      check("t4c_selftrig_addr", 32'(ddr3_rd_start_addr), 32'h400000);
      abort();
      set_hdr(3, make_hdr(24'd1, 23'h7ffffe, 1'b0, 1'b0, 1'b1));
      run_sm = 1'b1;
      run_to_ddr3("t4d_reach");
      check("t4d_field_addr", 32'(ddr3_rd_start_addr), 32'h7ffffe);
      abort();
      chan_sel = 3'd5; clr_mon(); run_sm = 1'b1;
      wait_done("t4e_done");
      check("t4e_bad_chan_err", 32'(err_code), 3);
      check("t4e_no_rd_en", rd_pulses, 0);
      step();
      set_hdr(3, make_hdr(24'd0, 23'h1234, 1'b0, 1'b0, 1'b0));
      chan_sel = 3'd3; clr_mon(); run_sm = 1'b1;
      wait_done("t4f_done");
      check("t4f_zero_burst_err", 32'(err_code), 3);
      check("t4f_pop_still", rd_pulses, 1);
      check("t4f_no_enable", en_cnt, 0);
      check("t4f_tlast", tl_cnt, 1);
      step();
      check("t4_fill_count", 32'(fill_count), 1);

      // Backpressure in ECHO_CC1, then abort mid GET_DDR3.
      set_hdr(2, make_hdr(24'd1, 23'h55, 1'b0, 1'b0, 1'b0));
      chan_sel = 3'd2; run_sm = 1'b1;
      n = 0;
      while (!send_cmd && n < 40) begin
         step();
         n++;
      end
      check("t5_reach_cc1", 32'(send_cmd), 1);
      tx_tready = 1'b0; clr_mon();
      repeat (20) step();
      check("t5_tvalid_held_off", tv_cnt, 0);
      check("t5_cmd_held", 32'(send_cmd), 1);
      tx_tready = 1'b1;
      step();
      check("t5_cc2_tvalid", 32'(tx_tvalid), 1);
      step();
      check("t5_in_ddr3", 32'(enable_reading), 1);
      aurora_ddr3_accept = 1'b1;
      step(); step();
      aurora_ddr3_accept = 1'b0;
      abort();
      check("t5_abort_outs", 32'(ctrl_outs), 0);
      check("t5_abort_fill", 32'(fill_count), 1);

      // reading_done before the last accept.
      clr_mon(); run_sm = 1'b1;
      run_to_ddr3("t6a_reach");
      reading_done = 1'b1;
      repeat (5) step();
      check("t6a_no_done_words4", done_cnt, 0);
      aurora_ddr3_accept = 1'b1;
      repeat (3) step();
      aurora_ddr3_accept = 1'b0;
      step(); step();
      check("t6a_no_done_words1", done_cnt, 0);
      aurora_ddr3_accept = 1'b1;
      step();
      aurora_ddr3_accept = 1'b0;
      n = 0;
      while (!sm_done && n < 10) begin
         step();
         n++;
      end
      check("t6a_done_latency", n, 1);
      run_sm = 1'b0; reading_done = 1'b0;
      step();
      check("t6a_fill_count", 32'(fill_count), 2);

      // Extra accepts at zero must saturate.
      clr_mon(); run_sm = 1'b1;
      run_to_ddr3("t6b_reach");
      aurora_ddr3_accept = 1'b1;
      repeat (7) step();
      aurora_ddr3_accept = 1'b0;
      step();
      check("t6b_wait_rd_done", 32'(enable_reading), 1);
      check("t6b_no_done", done_cnt, 0);
      reading_done = 1'b1;
      wait_done("t6b_done_after_saturate");
      check("t6b_fill_count", 32'(fill_count), 3);
      step();

      check("never_multihot_rd_en", multihot_all, 0);
      check("echo_selects_exclusive", overlap_all, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
